// File: rtl/muldiv_pkg.sv
// Shared constants for the MiniMips iterative multiply/divide unit:
// op encodings, FSM state encoding and the iteration-counter width helper.
package muldiv_pkg;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_REM  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // Counter width for the default 32-bit datapath.
    localparam int MULDIV_CNT_W = 5;

    // Counter width needed to count DATA_WIDTH iterations (0..width-1).
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign helpers for signed multiply/divide: operand magnitudes
// on the way in, conditional negation of product/quotient/remainder on the
// way out. Only instantiated when MULDIV_SIGNED_EN is defined.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic             is_signed,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic [W-1:0]     mag_a,
    output logic [W-1:0]     mag_b,
    output logic             sign_a,
    output logic             sign_b,
    input  logic [2*W-1:0]   prod,
    input  logic             prod_neg,
    output logic [2*W-1:0]   prod_fix,
    input  logic [W-1:0]     quot,
    input  logic             quot_neg,
    output logic [W-1:0]     quot_fix,
    input  logic [W-1:0]     rem,
    input  logic             rem_neg,
    output logic [W-1:0]     rem_fix
);

    assign sign_a   = is_signed & a[W-1];
    assign sign_b   = is_signed & b[W-1];
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign mag_a    = sign_a ? (~a + {{(W-1){1'b0}}, 1'b1}) : a;
    assign mag_b    = sign_b ? (~b + {{(W-1){1'b0}}, 1'b1}) : b;
    assign prod_fix = prod_neg ? (~prod + {{(2*W-1){1'b0}}, 1'b1}) : prod;
    assign quot_fix = quot_neg ? (~quot + {{(W-1){1'b0}}, 1'b1}) : quot;
    assign rem_fix  = rem_neg  ? (~rem  + {{(W-1){1'b0}}, 1'b1}) : rem;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply/divide unit feeding the register file write port.
// One shift-add (multiply) or restoring (divide) step per clock; DATA_WIDTH
// steps per operation. Optional signed support is enabled by defining
// MULDIV_SIGNED_EN; without it op_signed is ignored and no sign logic exists.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [1:0]                op,
    input  logic                      op_signed,
    input  logic [DATA_WIDTH-1:0]     operand_a,
    input  logic [DATA_WIDTH-1:0]     operand_b,
    input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
    output logic                      busy,
    output logic                      done,
    output logic                      reg_write,
    output logic [DATA_WIDTH-1:0]     result,
    output logic [REG_ADDR_WIDTH-1:0] write_reg
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    logic [1:0]                state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [W-1:0]              a_r;
    logic [W-1:0]              b_r;
    logic [1:0]                op_r;
    logic [REG_ADDR_WIDTH-1:0] dest_r;
    logic [W-1:0]              acc_hi_r;
    logic [W-1:0]              acc_lo_r;
    logic [W-1:0]              result_r;
    logic [REG_ADDR_WIDTH-1:0] write_reg_r;

    logic [W-1:0]              a_in_s;
    logic [W-1:0]              b_in_s;
    logic [W:0]                mul_sum_s;
    logic [W:0]                div_shift_s;
    logic [W-1:0]              div_diff_s;
    logic [CNT_W-1:0]          div_idx_s;
    logic [W-1:0]              hi_nx_s;
    logic [W-1:0]              lo_nx_s;
    logic [2*W-1:0]            prod_fin_s;
    logic [W-1:0]              quot_fin_s;
    logic [W-1:0]              rem_fin_s;
    logic [W-1:0]              res_sel_s;

    assign busy      = (state_r != ST_IDLE);
    assign done      = (state_r == ST_DONE);
    assign reg_write = (state_r == ST_DONE);
    assign result    = result_r;
    assign write_reg = write_reg_r;
    assign div_idx_s = CNT_LAST - cnt_r;

`ifdef MULDIV_SIGNED_EN
    logic sign_a_s;
    logic sign_b_s;
    logic sign_a_r;
    logic sign_b_r;

    muldiv_sign_fix #(.W(W)) u_sign_fix (
        .is_signed (op_signed),
        .a         (operand_a),
        .b         (operand_b),
        .mag_a     (a_in_s),
        .mag_b     (b_in_s),
        .sign_a    (sign_a_s),
        .sign_b    (sign_b_s),
        .prod      ({hi_nx_s, lo_nx_s}),
        .prod_neg  (sign_a_r ^ sign_b_r),
        .prod_fix  (prod_fin_s),
        .quot      (lo_nx_s),
        .quot_neg  ((sign_a_r ^ sign_b_r) & (b_r != {W{1'b0}})),
        .quot_fix  (quot_fin_s),
        .rem       (hi_nx_s),
        .rem_neg   (sign_a_r),
        .rem_fix   (rem_fin_s)
    );

    // Operand sign flags captured at acceptance for the fix-up entering DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && start) begin
            sign_a_r <= sign_a_s;
            sign_b_r <= sign_b_s;
        end else begin
            sign_a_r <= sign_a_r;
            sign_b_r <= sign_b_r;
        end
    end
`else
    logic op_signed_unused_s;

    assign op_signed_unused_s = op_signed;
    assign a_in_s     = operand_a;
    assign b_in_s     = operand_b;
    assign prod_fin_s = {hi_nx_s, lo_nx_s};
    assign quot_fin_s = lo_nx_s;
    assign rem_fin_s  = hi_nx_s;
`endif

    // One radix-2 step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (b_r[cnt_r] ? {1'b0, a_r} : {(W+1){1'b0}});
        div_shift_s = {acc_hi_r, a_r[div_idx_s]};
        div_diff_s  = div_shift_s[W-1:0] - b_r;
        if (op_r[1] == 1'b0) begin
            hi_nx_s = mul_sum_s[W:1];
            lo_nx_s = {mul_sum_s[0], acc_lo_r[W-1:1]};
        end else if (div_shift_s >= {1'b0, b_r}) begin
            hi_nx_s = div_diff_s;
            lo_nx_s = {acc_lo_r[W-2:0], 1'b1};
        end else begin
            hi_nx_s = div_shift_s[W-1:0];
            lo_nx_s = {acc_lo_r[W-2:0], 1'b0};
        end
    end

    // Select the architectural result word from the final step's outputs.
    always_comb begin
        case (op_r)
            OP_MUL:  res_sel_s = prod_fin_s[W-1:0];
            OP_MULH: res_sel_s = prod_fin_s[2*W-1:W];
            OP_DIV:  res_sel_s = quot_fin_s;
            OP_REM:  res_sel_s = rem_fin_s;
            default: res_sel_s = {W{1'b0}};
        endcase
    end

    // Control FSM, operand latching, iteration state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            op_r        <= 2'b00;
            dest_r      <= {REG_ADDR_WIDTH{1'b0}};
            acc_hi_r    <= {W{1'b0}};
            acc_lo_r    <= {W{1'b0}};
            result_r    <= {W{1'b0}};
            write_reg_r <= {REG_ADDR_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r      <= a_in_s;
                        b_r      <= b_in_s;
                        op_r     <= op;
                        dest_r   <= dest_reg;
                        acc_hi_r <= {W{1'b0}};
                        acc_lo_r <= {W{1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                        state_r  <= ST_CALC;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_CALC: begin
                    acc_hi_r <= hi_nx_s;
                    acc_lo_r <= lo_nx_s;
                    if (cnt_r == CNT_LAST) begin
                        result_r    <= res_sel_s;
                        write_reg_r <= dest_r;
                        cnt_r       <= {CNT_W{1'b0}};
                        state_r     <= ST_DONE;
                    end else begin
                        cnt_r       <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r     <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized
// operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        op_signed;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [2:0]  dest_reg;
    logic        busy;
    logic        done;
    logic        reg_write;
    logic [31:0] result;
    logic [2:0]  write_reg;

    int checks   = 0;
    int failures = 0;

    muldiv_unit #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .op_signed (op_signed),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .dest_reg  (dest_reg),
        .busy      (busy),
        .done      (done),
        .reg_write (reg_write),
        .result    (result),
        .write_reg (write_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition of each op.
    function automatic logic [31:0] model(input logic [1:0] o, input logic s,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        logic        sgn;
        sgn = 1'b0;
`ifdef MULDIV_SIGNED_EN
        sgn = s;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 2'b00 || o == 2'b01) begin
            if (sgn) p = 64'(sa * sb);
            else     p = {32'd0, a} * {32'd0, b};
            return (o == 2'b01) ? p[63:32] : p[31:0];
        end
        if (b == 32'd0) return (o == 2'b11) ? a : 32'hFFFF_FFFF;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return (o == 2'b11) ? 32'd0 : 32'h8000_0000;
            p = (o == 2'b11) ? 64'(sa % sb) : 64'(sa / sb);
            return p[31:0];
        end
        return (o == 2'b11) ? (a % b) : (a / b);
    endfunction

    // Issue one operation, check latency, strobe, result, write_reg and busy.
    task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] d, input bit disturb);
        logic [31:0] exp;
        int          got;
        bit          busy_bad;
        exp      = model(o, s, a, b);
        got      = 0;
        busy_bad = 1'b0;
        @(negedge clk);
        op = o; op_signed = s; operand_a = a; operand_b = b; dest_reg = d;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done === 1'b1) begin
                got = k;
                break;
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (disturb && (k == 4 || k == 31)) begin
                start     = 1'b1;
                op        = 2'(k);
                op_signed = ~s;
                operand_a = $urandom;
                operand_b = $urandom;
                dest_reg  = ~d;
            end
        end
        check({tag, " latency"}, 64'(got), 64'd32);
        check({tag, " result"}, 64'(result), 64'(exp));
        check({tag, " write_reg"}, 64'(write_reg), 64'(d));
        check({tag, " reg_write"}, 64'(reg_write), 64'd1);
        check({tag, " busy_calc"}, 64'(busy_bad), 64'd0);
        @(posedge clk);
        #1;
        check({tag, " done_pulse"}, 64'(done), 64'd0);
        check({tag, " result_hold"}, 64'(result), 64'(exp));
    endtask

    int rw_seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; op_signed = 1'b0;
        operand_a = 32'd0; operand_b = 32'd0; dest_reg = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset reg_write", 64'(reg_write), 64'd0);
        check("reset result", 64'(result), 64'd0);
        check("reset write_reg", 64'(write_reg), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("mul_7x6", 2'b00, 1'b0, 32'd7, 32'd6, 3'd3, 1'b0);
        run_op("mulh_ff", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 1'b0);
        run_op("mul_ff", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 1'b0);
        run_op("div_100_7", 2'b10, 1'b0, 32'd100, 32'd7, 3'd4, 1'b0);
        run_op("rem_100_7", 2'b11, 1'b0, 32'd100, 32'd7, 3'd5, 1'b0);
        run_op("div_5_0", 2'b10, 1'b0, 32'd5, 32'd0, 3'd6, 1'b0);
        run_op("rem_5_0", 2'b11, 1'b0, 32'd5, 32'd0, 3'd0, 1'b0);
        run_op("ignored_start", 2'b00, 1'b0, 32'd12345, 32'd678, 3'd7, 1'b1);

        // Reset in the middle of CALC: outputs clear at once, no write ever appears.
        @(negedge clk);
        op = 2'b00; op_signed = 1'b0; operand_a = 32'd123; operand_b = 32'd456; dest_reg = 3'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort busy", 64'(busy), 64'd0);
        check("abort done", 64'(done), 64'd0);
        check("abort reg_write", 64'(reg_write), 64'd0);
        check("abort result", 64'(result), 64'd0);
        check("abort write_reg", 64'(write_reg), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rw_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (reg_write === 1'b1) rw_seen++;
        end
        check("abort no_write", 64'(rw_seen), 64'd0);
        run_op("after_abort", 2'b00, 1'b0, 32'd123, 32'd456, 3'd5, 1'b0);

`ifdef MULDIV_SIGNED_EN
        run_op("sdiv_m7_2", 2'b10, 1'b1, 32'hFFFF_FFF9, 32'd2, 3'd1, 1'b0);
        run_op("srem_m7_2", 2'b11, 1'b1, 32'hFFFF_FFF9, 32'd2, 3'd2, 1'b0);
        run_op("sdiv_ovf", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3'd3, 1'b0);
        run_op("srem_ovf", 2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 1'b0);
        run_op("smulh_m1", 2'b01, 1'b1, 32'hFFFF_FFFF, 32'd3, 3'd5, 1'b0);
`endif

        for (int i = 0; i < 20; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 :
                 (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 1000)) : 32'($urandom));
            run_op("random", 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ra, rb, 3'($urandom_range(0, 7)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
